// File: rtl/isa_pkg.sv
// Shared instruction-set definitions for the load/store executors: opcodes,
// store FSM state encoding and tile geometry helper.
package isa_pkg;

  localparam logic [4:0] OPC_LOAD_V = 5'h01;
  localparam logic [4:0] OPC_LOAD_M = 5'h02;
  localparam logic [4:0] OPC_STORE  = 5'h03;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ_TILE,
    ST_WAIT_TILE,
    ST_WRITE,
    ST_COMPLETE
  } store_state_t;

  function automatic int tile_elems(input int tile_width, input int data_width);
    return tile_width / data_width;
  endfunction

endpackage

// File: rtl/tile_serializer.sv
// Holds one captured tile and walks it element by element; the element index
// advances on each accepted (valid && ack) beat and runs across tile reloads.
module tile_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int TILE_ELEMS = 32,
  parameter int IDX_W      = 10
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  clear,
  input  logic                                  load,
  input  logic [TILE_ELEMS-1:0][DATA_WIDTH-1:0] tile_in,
  input  logic                                  out_valid,
  input  logic                                  out_ack,
  output logic [IDX_W-1:0]                      elem_idx,
  output logic [DATA_WIDTH-1:0]                 out_data
);

  localparam int SEL_W = $clog2(TILE_ELEMS);

  logic [TILE_ELEMS-1:0][DATA_WIDTH-1:0] tile_q, tile_d;
  logic [IDX_W-1:0]                      idx_q, idx_d;

  always_comb begin
    tile_d = tile_q;
    idx_d  = idx_q;
    if (clear)              idx_d  = '0;
    if (load)               tile_d = tile_in;
    if (out_valid && out_ack) idx_d = idx_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tile_q <= '0;
      idx_q  <= '0;
    end else begin
      tile_q <= tile_d;
      idx_q  <= idx_d;
    end
  end

  // Low index bits select the slot within the current tile.
  assign elem_idx = idx_q;
  assign out_data = tile_q[idx_q[SEL_W-1:0]];

endmodule

// File: rtl/store_execution.sv
// STORE executor: fetches tiles from the buffer controller and writes them to
// DRAM one element per handshake. Optional STORE_EXEC_TIMEOUT_EN adds a write-ack timeout.
module store_execution
  import isa_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int TILE_WIDTH = 256,
  parameter int TILE_ELEMS = tile_elems(TILE_WIDTH, DATA_WIDTH),
  parameter int ADDR_WIDTH = 24
`ifdef STORE_EXEC_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         start,
  input  logic [4:0]                                   opcode,
  input  logic [4:0]                                   src_buffer_id,
  input  logic [9:0]                                   length,
  input  logic [ADDR_WIDTH-1:0]                        addr,
  output logic                                         done,
  output logic                                         buf_read_req,
  output logic [4:0]                                   buf_read_buffer_id,
  input  logic signed [TILE_ELEMS-1:0][DATA_WIDTH-1:0] buf_read_tile,
  input  logic                                         buf_read_valid,
  output logic                                         mem_we,
  output logic [ADDR_WIDTH-1:0]                        mem_addr,
  output logic [DATA_WIDTH-1:0]                        mem_wdata,
  input  logic                                         mem_ack
`ifdef STORE_EXEC_TIMEOUT_EN
  , output logic                                       error
`endif
);

  localparam int SEL_W = $clog2(TILE_ELEMS);

  store_state_t          state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [9:0]            len_q, len_d;
  logic [4:0]            buf_id_q, buf_id_d;
  logic [5:0]            tile_cnt_q, tile_cnt_d;

  logic                  ser_clear, ser_load, ser_valid;
  logic [9:0]            ser_idx, idx_nxt;
  logic [DATA_WIDTH-1:0] ser_data;

`ifdef STORE_EXEC_TIMEOUT_EN
  localparam int SW = $clog2(TIMEOUT_CYCLES + 1);
  logic [SW-1:0] stall_q, stall_d;
  logic          error_q, error_d;
`endif

  assign idx_nxt = ser_idx + 10'd1;

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    len_d      = len_q;
    buf_id_d   = buf_id_q;
    tile_cnt_d = tile_cnt_q;
    ser_clear  = 1'b0;
    ser_load   = 1'b0;
    ser_valid  = 1'b0;
`ifdef STORE_EXEC_TIMEOUT_EN
    stall_d    = stall_q;
    error_d    = error_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          base_d     = addr;
          len_d      = length;
          buf_id_d   = src_buffer_id;
          tile_cnt_d = '0;
          ser_clear  = 1'b1;
`ifdef STORE_EXEC_TIMEOUT_EN
          error_d    = 1'b0;
          stall_d    = '0;
`endif
          if (opcode != OPC_STORE || length == 10'd0) state_d = ST_COMPLETE;
          else                                        state_d = ST_REQ_TILE;
        end
      end
      ST_REQ_TILE: begin
        tile_cnt_d = tile_cnt_q + 6'd1;
        state_d    = ST_WAIT_TILE;
      end
      ST_WAIT_TILE: begin
        if (buf_read_valid) begin
          ser_load = 1'b1;
          state_d  = ST_WRITE;
        end
      end
      ST_WRITE: begin
        ser_valid = 1'b1;
        if (mem_ack) begin
`ifdef STORE_EXEC_TIMEOUT_EN
          stall_d = '0;
`endif
          // Last element wins over the tile boundary when both coincide.
          if (idx_nxt == len_q)                state_d = ST_COMPLETE;
          else if (idx_nxt[SEL_W-1:0] == '0)   state_d = ST_REQ_TILE;
        end
`ifdef STORE_EXEC_TIMEOUT_EN
        else if (stall_q == SW'(TIMEOUT_CYCLES - 1)) begin
          stall_d = '0;
          error_d = 1'b1;
          state_d = ST_COMPLETE;
        end else begin
          stall_d = stall_q + 1'b1;
        end
`endif
      end
      ST_COMPLETE: state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      base_q     <= '0;
      len_q      <= '0;
      buf_id_q   <= '0;
      tile_cnt_q <= '0;
`ifdef STORE_EXEC_TIMEOUT_EN
      stall_q    <= '0;
      error_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      len_q      <= len_d;
      buf_id_q   <= buf_id_d;
      tile_cnt_q <= tile_cnt_d;
`ifdef STORE_EXEC_TIMEOUT_EN
      stall_q    <= stall_d;
      error_q    <= error_d;
`endif
    end
  end

  tile_serializer #(
    .DATA_WIDTH (DATA_WIDTH),
    .TILE_ELEMS (TILE_ELEMS),
    .IDX_W      (10)
  ) u_ser (
    .clk       (clk),
    .rst       (rst),
    .clear     (ser_clear),
    .load      (ser_load),
    .tile_in   (buf_read_tile),
    .out_valid (ser_valid),
    .out_ack   (mem_ack),
    .elem_idx  (ser_idx),
    .out_data  (ser_data)
  );

  assign done               = (state_q == ST_COMPLETE);
  assign buf_read_req       = (state_q == ST_REQ_TILE);
  assign buf_read_buffer_id = buf_id_q;
  assign mem_we             = (state_q == ST_WRITE);
  // Memory port is driven only while a write is being offered.
  assign mem_addr           = mem_we ? base_q + ADDR_WIDTH'(ser_idx) : '0;
  assign mem_wdata          = mem_we ? ser_data : '0;
`ifdef STORE_EXEC_TIMEOUT_EN
  assign error              = error_q;
`endif

endmodule

// File: doc/store_execution.md
Name: store_execution

Overview:
Executes STORE (opcode 0x03): reads vector tiles from the buffer controller and writes them element-by-element to DRAM over the unified memory interface.
- It is the write-direction counterpart of the load path and shares the same addr/length/buffer-id instruction fields.
- It sits beside the load executor under the instruction dispatcher.
- It drives the memory port only while busy.

Parameters:
DATA_WIDTH, 8, element width in bits
TILE_WIDTH, 256, tile width in bits
TILE_ELEMS, TILE_WIDTH/DATA_WIDTH, elements per tile (32)
ADDR_WIDTH, 24, DRAM byte-address width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle launch pulse, sampled only in IDLE
opcode  in  5  0x03=STORE; any other value is a no-op
src_buffer_id  in  5  buffer to read from
length  in  10  elements to store (0..1023)
addr  in  ADDR_WIDTH  DRAM base byte address
done  out  1  one-cycle completion pulse
buf_read_req  out  1  one-cycle tile read request
buf_read_buffer_id  out  5  equals the latched src_buffer_id
buf_read_tile  in  TILE_ELEMS x DATA_WIDTH signed  returned tile, element 0 = lowest address
buf_read_valid  in  1  buf_read_tile is valid this cycle
mem_we  out  1  write request, held until acknowledged
mem_addr  out  ADDR_WIDTH  write address
mem_wdata  out  DATA_WIDTH  write data
mem_ack  in  1  write accepted this cycle

Behaviour:
- Reset values: all outputs are 0; state = IDLE; internal counters are 0.
- rst asserted mid-operation aborts immediately. No done pulse; mem_we drops the next cycle.
- Latching: on start in IDLE, addr, length and src_buffer_id are latched. Later input changes are ignored until done.
- States: IDLE, REQ_TILE, WAIT_TILE, WRITE, COMPLETE.
- IDLE transitions on start:
  - opcode != 0x03 -> COMPLETE, with no buffer or memory activity.
  - length == 0 -> COMPLETE.
  - otherwise -> REQ_TILE.
- REQ_TILE: buf_read_req = 1 for exactly one cycle, then -> WAIT_TILE.
- WAIT_TILE:
  - Waits any number of cycles for buf_read_valid.
  - On valid, captures the whole tile into an internal register, then -> WRITE.
  - buf_read_valid in any other state is ignored.
- WRITE:
  - mem_we = 1, mem_addr = base + elem_idx, mem_wdata = tile_reg[elem_idx mod TILE_ELEMS].
  - mem_addr and mem_wdata are stable while mem_we is high and mem_ack is low.
  - On mem_ack: elem_idx increments.
    - If elem_idx+1 == length -> COMPLETE.
    - Else if (elem_idx+1) mod TILE_ELEMS == 0 -> REQ_TILE.
    - Otherwise stay in WRITE with the next element; mem_we stays high, giving back-to-back writes with no bubble.
- COMPLETE: done = 1 for one cycle, then -> IDLE. A new start is accepted on the cycle after done.
- Partial last tile: only length mod TILE_ELEMS elements are written; upper elements are never written.
- Address arithmetic: modulo 2^ADDR_WIDTH, so 0xFFFFFF + 1 -> 0x000000 with no error.
- Tile counter: width 6, holding ceil(length/TILE_ELEMS) ≤ 32. Element counter width is 10.
- Throughput: 1 element/cycle when mem_ack is held high. Each tile adds 2 + buffer-latency cycles of overhead.
- mem_ack while mem_we = 0 is ignored.

Optional Feature:
STORE_EXEC_TIMEOUT_EN
- Defined:
  - Adds parameter TIMEOUT_CYCLES (default 1024) and output port error (1 bit, reset 0).
  - If mem_we stays high without mem_ack for TIMEOUT_CYCLES consecutive cycles, mem_we drops and the FSM goes to COMPLETE.
  - done pulses together with error = 1. error stays high until the next accepted start.
- Undefined: no port, no counter; the block waits for mem_ack indefinitely.

Decomposition:
- Shared package isa_pkg holds:
  - OPC_LOAD_V = 5'h01, OPC_LOAD_M = 5'h02, OPC_STORE = 5'h03
  - the store_state_t enum
  - TILE_ELEMS derivation
- One natural sub-module: tile_serializer. It holds the tile register and element index and emits elements under a valid/ack handshake. The FSM in store_execution handles tile fetch and completion.

Test Plan:
- STORE, length=5, addr=0x000100, mem_ack tied 1 -> one buf_read_req; writes to 0x100..0x104 of tile[0..4] on consecutive cycles; done on the cycle after the 5th ack.
- STORE, length=70, src_buffer_id=9 -> exactly 3 buf_read_req, each with buffer_id 9; 70 writes; third tile contributes elements 0..5 only.
- mem_ack asserted every 3rd cycle -> mem_addr/mem_wdata stable across stalls; no element duplicated or skipped.
- opcode=0x01 or length=0 -> done 1 cycle after start (2 cycles after start edge); zero buf_read_req and mem_we.
- addr=0xFFFFFE, length=4 -> addresses 0xFFFFFE, 0xFFFFFF, 0x000000, 0x000001.
- rst pulsed during the 10th write -> all outputs 0 next cycle; no done; a fresh STORE afterwards completes normally.
